// File: rtl/bram_axis_pkg.sv
// Shared types and default sizes for the BRAM-to-AXI-Stream reader.
package bram_axis_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_NUM_BRAM   = 8;
  localparam int SEL_WIDTH      = 3;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/bram_axis_reader_fifo.sv
// Two-entry skid FIFO holding returned BRAM words ahead of the stream port.
module axis_skid_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/bram_axis_reader.sv
// Streams words from a range of BRAMs out of an AXI-Stream master.
// Define BRAM_AXIS_TLAST_PER_BRAM_EN to close a packet after every BRAM.
module bram_axis_reader
  import bram_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BRAM   = DEF_NUM_BRAM
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         start,
  input  logic [SEL_WIDTH-1:0]         rd_bram_start,
  input  logic [SEL_WIDTH-1:0]         rd_bram_end,
  input  logic [CNT_WIDTH-1:0]         rd_addr_start,
  input  logic [CNT_WIDTH-1:0]         rd_addr_count,
  output logic [ADDR_WIDTH-1:0]        bram_rd_addr,
  output logic [SEL_WIDTH-1:0]         bram_rd_sel,
  output logic                         bram_rd_en,
  input  logic [NUM_BRAM*DATA_WIDTH-1:0] bram_rd_data_flat,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         read_done,
  output logic                         param_err
);

  localparam int FW = DATA_WIDTH + 2;

  state_t state, state_nxt;

  logic [SEL_WIDTH-1:0]  b_cur;
  logic [SEL_WIDTH-1:0]  b_end;
  logic [ADDR_WIDTH-1:0] a_start;
  logic [CNT_WIDTH-1:0]  a_count;
  logic [CNT_WIDTH-1:0]  k;
  logic [ADDR_WIDTH-1:0] addr;

  logic                  rd_q;
  logic                  last_q;
  logic                  fin_q;
  logic [SEL_WIDTH-1:0]  sel_q;

  logic                  issue;
  logic                  k_last;
  logic                  b_last;
  logic                  issue_last;
  logic                  bad_order;
  logic                  no_words;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [1:0]            fcnt;
  logic [2:0]            occ;
  logic [FW-1:0]         fdin;
  logic [FW-1:0]         fdout;

  logic [DATA_WIDTH-1:0] words [NUM_BRAM];

  for (genvar i = 0; i < NUM_BRAM; i++) begin : g_word
    assign words[i] = bram_rd_data_flat[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bad_order = (rd_bram_end < rd_bram_start);
  assign no_words  = (rd_addr_count == '0);
  assign k_last    = (k == a_count - 16'd1);
  assign b_last    = (b_cur == b_end);

`ifdef BRAM_AXIS_TLAST_PER_BRAM_EN
  assign issue_last = k_last;
`else
  assign issue_last = k_last && b_last;
`endif

  // Credit counts the word already in flight and frees the slot being popped.
  assign pop   = !empty && m_axis_tready;
  assign occ   = {2'b0, rd_q} + {1'b0, fcnt} - {2'b0, pop};
  assign issue = (state == ISSUE) && (occ < 3'd2);

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    read_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (bad_order || no_words) state_nxt = DONE;
          else                       state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && k_last && b_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && fdout[DATA_WIDTH+1]) state_nxt = DONE;
      end
      DONE: begin
        read_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      b_cur     <= '0;
      b_end     <= '0;
      a_start   <= '0;
      a_count   <= '0;
      k         <= '0;
      addr      <= '0;
      param_err <= 1'b0;
      rd_q      <= 1'b0;
      last_q    <= 1'b0;
      fin_q     <= 1'b0;
      sel_q     <= '0;
    end else begin
      if (state == IDLE && start) begin
        b_cur     <= rd_bram_start;
        b_end     <= rd_bram_end;
        a_start   <= rd_addr_start[ADDR_WIDTH-1:0];
        a_count   <= rd_addr_count;
        k         <= '0;
        addr      <= rd_addr_start[ADDR_WIDTH-1:0];
        param_err <= bad_order;
      end else if (issue) begin
        if (k_last) begin
          k    <= '0;
          addr <= a_start;
          if (!b_last) b_cur <= b_cur + 3'd1;
        end else begin
          k    <= k + 16'd1;
          addr <= addr + ADDR_WIDTH'(1);
        end
      end
      rd_q   <= issue;
      last_q <= issue_last;
      fin_q  <= k_last && b_last;
      sel_q  <= b_cur;
    end
  end

  assign push = rd_q && (!full || pop);
  assign fdin = {fin_q, last_q, words[sel_q]};

  axis_skid_fifo #(
    .WIDTH (FW)
  ) u_skid (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .pop   (pop),
    .din   (fdin),
    .dout  (fdout),
    .full  (full),
    .empty (empty),
    .count (fcnt)
  );

  assign bram_rd_addr  = addr;
  assign bram_rd_sel   = b_cur;
  assign bram_rd_en    = issue;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : fdout[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !empty && fdout[DATA_WIDTH];

endmodule

// File: tb/tb_bram_axis_reader.sv
// Randomized self-checking bench for bram_axis_reader against a batch model.
module tb_bram_axis_reader;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int NB = 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic            start;
  logic [2:0]      rd_bram_start;
  logic [2:0]      rd_bram_end;
  logic [15:0]     rd_addr_start;
  logic [15:0]     rd_addr_count;
  logic [AW-1:0]   bram_rd_addr;
  logic [2:0]      bram_rd_sel;
  logic            bram_rd_en;
  logic [NB*DW-1:0] bram_rd_data_flat = '0;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            busy;
  logic            read_done;
  logic            param_err;

  bram_axis_reader dut (
    .aclk              (aclk),
    .areset            (areset),
    .start             (start),
    .rd_bram_start     (rd_bram_start),
    .rd_bram_end       (rd_bram_end),
    .rd_addr_start     (rd_addr_start),
    .rd_addr_count     (rd_addr_count),
    .bram_rd_addr      (bram_rd_addr),
    .bram_rd_sel       (bram_rd_sel),
    .bram_rd_en        (bram_rd_en),
    .bram_rd_data_flat (bram_rd_data_flat),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .busy              (busy),
    .read_done         (read_done),
    .param_err         (param_err)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] bram [NB][512];

  always @(posedge aclk) begin
    if (bram_rd_en)
      for (int i = 0; i < NB; i++)
        bram_rd_data_flat[i*DW +: DW] <= bram[i][bram_rd_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW:0] exp_q [$];
  logic [11:0] rdx_q [$];
  int          exp_tl;

  int  beats, tlasts, first_cyc, last_cyc, done_cyc;
  bit  done_seen;
  bit  pv_stall;
  logic [DW:0] pv_beat;
  int  tr_mode = 0;

  always @(negedge aclk) begin
    logic [DW:0] e;
    logic [11:0] r;
    if (!areset) begin
      if (bram_rd_en) begin
        if (rdx_q.size() == 0) check("extra_read", 1, 0);
        else begin
          r = rdx_q.pop_front();
          check("rd_sel", {29'd0, bram_rd_sel}, {29'd0, r[11:9]});
          check("rd_addr", {23'd0, bram_rd_addr}, {23'd0, r[8:0]});
        end
      end
      if (pv_stall) begin
        check("stall_valid", {31'd0, m_axis_tvalid}, 1);
        check("stall_beat", {m_axis_tlast, m_axis_tdata}, pv_beat);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (m_axis_tlast) tlasts++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
      if (read_done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      pv_stall = m_axis_tvalid && !m_axis_tready;
      pv_beat  = {m_axis_tlast, m_axis_tdata};
    end else begin
      pv_stall = 1'b0;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic build_model(input int s, input int e, input logic [15:0] as,
                             input logic [15:0] cnt);
    logic [15:0] sum;
    logic        lst;
    exp_q.delete();
    rdx_q.delete();
    exp_tl = 0;
    if (cnt != 0 && e >= s)
      for (int b = s; b <= e; b++)
        for (int k = 0; k < int'(cnt); k++) begin
          sum = as + 16'(k);
`ifdef BRAM_AXIS_TLAST_PER_BRAM_EN
          lst = (k == int'(cnt) - 1);
`else
          lst = (b == e) && (k == int'(cnt) - 1);
`endif
          if (lst) exp_tl++;
          exp_q.push_back({lst, bram[b][sum[8:0]]});
          rdx_q.push_back({3'(b), sum[8:0]});
        end
  endtask

  task automatic launch(input int s, input int e, input logic [15:0] as,
                        input logic [15:0] cnt, input int mode,
                        output int st);
    @(posedge aclk);
    #1;
    tr_mode       = mode;
    beats         = 0;
    tlasts        = 0;
    first_cyc     = -1;
    last_cyc      = -1;
    done_cyc      = -1;
    done_seen     = 1'b0;
    rd_bram_start = 3'(s);
    rd_bram_end   = 3'(e);
    rd_addr_start = as;
    rd_addr_count = cnt;
    start         = 1'b1;
    st            = cyc;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_batch(input int s, input int e, input logic [15:0] as,
                           input logic [15:0] cnt, input int mode);
    int st, n, nb;
    build_model(s, e, as, cnt);
    nb = exp_q.size();
    launch(s, e, as, cnt, mode, st);
    @(negedge aclk);
    if (nb > 0) check("busy_run", {31'd0, busy}, 1);
    n = 0;
    while (!done_seen && n < 400) begin
      @(posedge aclk);
      n++;
    end
    #2;
    check("done_seen", {31'd0, done_seen}, 1);
    check("beat_count", beats, nb);
    check("tlast_count", tlasts, exp_tl);
    check("residual", exp_q.size(), 0);
    check("param_err", {31'd0, param_err}, {31'd0, e < s});
    if (nb > 0) begin
      check("done_lat", done_cyc - last_cyc, 1);
      if (mode == 0) begin
        check("first_lat", {31'd0, (first_cyc - st) <= 3}, 1);
        check("back2back", last_cyc - first_cyc + 1, nb);
      end
    end else begin
      check("empty_done", {31'd0, (done_cyc - st) <= 2}, 1);
    end
    @(posedge aclk);
    #1;
    check("idle_busy", {31'd0, busy}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, m_axis_tvalid}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_rden"}, {31'd0, bram_rd_en}, 0);
    check({tag, "_addr"}, {23'd0, bram_rd_addr}, 0);
    check({tag, "_sel"}, {29'd0, bram_rd_sel}, 0);
    check({tag, "_perr"}, {31'd0, param_err}, 0);
    check({tag, "_done"}, {31'd0, read_done}, 0);
    check({tag, "_last"}, {31'd0, m_axis_tlast}, 0);
    check({tag, "_data"}, {16'd0, m_axis_tdata}, 0);
  endtask

  initial begin
    int st, n, s, e;
    areset        = 1'b1;
    start         = 1'b0;
    rd_bram_start = '0;
    rd_bram_end   = '0;
    rd_addr_start = '0;
    rd_addr_count = '0;
    for (int i = 0; i < NB; i++)
      for (int a = 0; a < 512; a++)
        bram[i][a] = 16'($urandom);
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("rst");

    run_batch(0, 0, 16'd0, 16'd4, 0);
    run_batch(2, 3, 16'd100, 16'd3, 1);
    run_batch(1, 1, 16'd510, 16'd4, 0);
    run_batch(4, 6, 16'd509, 16'd5, 2);
    run_batch(0, 7, 16'd0, 16'd0, 0);
    run_batch(5, 1, 16'd0, 16'd3, 0);
    run_batch(0, 2, 16'd7, 16'd2, 0);

    build_model(0, 0, 16'd20, 16'd8);
    launch(0, 0, 16'd20, 16'd8, 0, st);
    n = 0;
    while (beats < 3 && n < 100) begin
      @(posedge aclk);
      n++;
    end
    check("pre_reset_beats", {31'd0, beats >= 3}, 1);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("mid_rst");
    run_batch(3, 4, 16'd300, 16'd6, 2);

    for (int t = 0; t < 14; t++) begin
      s = $urandom_range(0, 7);
      e = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7)
                                       : $urandom_range(s, 7);
      run_batch(s, e, 16'($urandom),
                16'($urandom_range(0, 9)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_axis_reader.md
BRAM_AXIS_READER -- requirements
Module: bram_axis_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one BRAM word and of one stream beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, BRAM address width (depth 512).
REQ-003 SHALL have parameter NUM_BRAM, default 8, number of readable BRAMs.
REQ-004 SHALL have ports:
- aclk  in  1  sole clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a batch.
- rd_bram_start  in  3  first BRAM index.
- rd_bram_end  in  3  last BRAM index (inclusive).
- rd_addr_start  in  16  first word address in each BRAM.
- rd_addr_count  in  16  words read per BRAM.
- bram_rd_addr  out  ADDR_WIDTH  shared read address.
- bram_rd_sel  out  3  BRAM being addressed.
- bram_rd_en  out  1  read strobe; data valid exactly 1 cycle later.
- bram_rd_data_flat  in  NUM_BRAM*DATA_WIDTH  BRAM i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  end of packet.
- busy  out  1  batch in progress.
- read_done  out  1  one-cycle pulse at batch end.
- param_err  out  1  sticky until the next start; batch rejected.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-006 SHALL in IDLE latch all rd_* inputs on start and go to ISSUE; start outside IDLE is ignored.
REQ-007 SHALL, if rd_addr_count==0 or rd_bram_end<rd_bram_start at start, go directly to DONE, emit no beats, and set param_err only for the BRAM-order violation.
REQ-008 SHALL in ISSUE walk BRAMs rd_bram_start..rd_bram_end, each over addresses rd_addr_start+k, k=0..rd_addr_count-1, with the address truncated to ADDR_WIDTH (wraps mod 2^ADDR_WIDTH).
REQ-009 SHALL assert bram_rd_en only when (in-flight reads + skid entries) < 2, so no returned word is ever dropped.
REQ-010 SHALL capture bram_rd_data_flat slice bram_rd_sel (delayed one cycle) into a 2-entry skid buffer; stream output is the buffer head.
REQ-011 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0; a beat transfers only on tvalid&&tready.
REQ-012 SHALL sustain 1 beat/cycle with tready held high; the first tvalid SHALL occur at most 3 cycles after start.
REQ-013 SHALL assert m_axis_tlast on the final word of the whole batch (last BRAM, last address) only.
REQ-014 SHALL go ISSUE->DRAIN after the last read is issued, DRAIN->DONE when the last beat handshakes, and DONE->IDLE after one cycle with read_done=1.
REQ-015 SHALL hold busy=1 in ISSUE, DRAIN and DONE; the batch beat count SHALL be exactly (end-start+1)*count.

Reset
REQ-016 SHALL on areset force IDLE, empty the skid buffer, cancel in-flight reads, and drive all outputs 0 (bram_rd_addr=0, bram_rd_sel=0, param_err=0) on the following cycle, including mid-batch.

Configuration
REQ-017 SHALL, with BRAM_AXIS_TLAST_PER_BRAM_EN defined, assert m_axis_tlast on the last word of every BRAM segment (one packet per BRAM); without it, behaviour is per REQ-013.

Structure
REQ-018 SHALL take state encodings and default widths from shared package bram_axis_pkg.
REQ-019 SHALL implement the 2-entry buffer as sub-module axis_skid_fifo (push, pop, full, empty, count).

Verification
REQ-020 Start 0..0, addr_start 0, count 4, tready=1 -> 4 beats of BRAM0 words 0..3 on consecutive cycles, tlast on beat 4, read_done one cycle later.
REQ-021 Start 2..3, count 3, tready toggling 1/0 -> 6 beats in order B2[0..2], B3[0..2], no loss or duplication, data stable while stalled.
REQ-022 addr_start 510, count 4 -> addresses 510, 511, 0, 1.
REQ-023 count 0 -> read_done within 2 cycles, no tvalid, param_err=0; end 1 < start 5 -> no beats, param_err=1.
REQ-024 areset after 3 of 8 beats -> tvalid=0, busy=0 next cycle; a fresh batch then streams correct data.
REQ-025 With BRAM_AXIS_TLAST_PER_BRAM_EN, start 0..2, count 2 -> tlast on beats 2, 4 and 6.
